// File: rtl/qdec.sv
`default_nettype none
// ============================================================================
// Module   : qdec
// Purpose  : Quadrature A/B decoder - input synchroniser, per-channel glitch
//            filter, X1/X2/X4 step/dir generation, illegal-transition flags.
// Revision : 1.0  initial release
// ============================================================================
module qdec #(
    parameter int    SYNC_STAGES = 2,
    parameter int    FILTER      = 4,
    parameter string MODE        = "X4",
    parameter int    INVERT      = 0
) (
    input  logic clk,
    input  logic aclr,
    input  logic a,
    input  logic b,
    input  logic en,
    input  logic clr_err,
    output logic step,
    output logic dir,
    output logic err,
    output logic err_sticky
);

    localparam int              C_CNT_W   = $clog2(FILTER + 1);
    localparam logic [C_CNT_W-1:0] C_FILT_M1 = C_CNT_W'(FILTER - 1);
    localparam logic            C_INV     = (INVERT != 0);
    localparam logic            C_X2      = (MODE == "X2");
    localparam logic            C_X1      = (MODE == "X1");

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("qdec: SYNC_STAGES must be in 2..4");
        end
        if (FILTER < 1 || FILTER > 255) begin : g_bad_filter
            $error("qdec: FILTER must be in 1..255");
        end
        if (MODE != "X4" && MODE != "X2" && MODE != "X1") begin : g_bad_mode
            $error("qdec: MODE must be X4, X2 or X1");
        end
        if (INVERT != 0 && INVERT != 1) begin : g_bad_invert
            $error("qdec: INVERT must be 0 or 1");
        end
    endgenerate

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {a, b};

    // Bit 1 carries phase A, bit 0 phase B.
    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q;
            logic [C_CNT_W-1:0]     cnt_q;
            logic [C_CNT_W-1:0]     cnt_d;
            logic                   f_q;
            logic                   f_d;

            always_comb begin
                cnt_d = '0;
                f_d   = f_q;
                if (sync_q[SYNC_STAGES-1] != f_q) begin
                    if (cnt_q == C_FILT_M1) begin
                        f_d = ~f_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge aclr) begin
                if (aclr) begin
                    sync_q <= '0;
                    cnt_q  <= '0;
                    f_q    <= 1'b0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], w_raw[ch]};
                    cnt_q  <= cnt_d;
                    f_q    <= f_d;
                end
            end

            assign w_filt[ch] = f_q;
        end
    endgenerate

    logic [1:0] prev_q;
    logic       step_q, step_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    logic       err_sticky_q, err_sticky_d;

    logic w_a_chg;
    logic w_b_chg;
    logic w_fwd;
    logic w_valid;
    logic w_qual;

    assign w_a_chg = prev_q[1] ^ w_filt[1];
    assign w_b_chg = prev_q[0] ^ w_filt[0];
    assign w_valid = w_a_chg ^ w_b_chg;
    // Forward Gray order: an A edge leaves A!=B, a B edge leaves A==B.
    assign w_fwd   = w_a_chg ? (w_filt[1] != w_filt[0]) : (w_filt[1] == w_filt[0]);
    assign w_qual  = C_X1 ? (w_valid & w_a_chg & ~w_filt[0]) :
                     C_X2 ? (w_valid & w_a_chg) :
                            w_valid;

    always_comb begin
        step_d       = 1'b0;
        dir_d        = dir_q;
        err_d        = w_a_chg & w_b_chg;
        err_sticky_d = err_d | (err_sticky_q & ~clr_err);
        if (w_qual && en) begin
            step_d = 1'b1;
            dir_d  = w_fwd ^ C_INV;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            prev_q       <= 2'b00;
            step_q       <= 1'b0;
            dir_q        <= ~C_INV;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            prev_q       <= w_filt;
            step_q       <= step_d;
            dir_q        <= dir_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;

endmodule
`default_nettype wire
